// File: rtl/ksa_nibble_seq_ctrl.sv
// rtl/ksa_nibble_seq_ctrl.sv - WIDTH-bit add/sub sequenced over one 4-bit Kogge-Stone slice
module ksa_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  bx_r;
    logic              carry;
    logic [IDXW-1:0]   idx;

    int                nib_lsb;
    logic [3:0]        na;
    logic [3:0]        nb;
    logic [3:0]        g;
    logic [3:0]        p;
    logic [3:0]        g0;
    logic [3:0]        g1;
    logic [3:0]        p1;
    logic [3:0]        g2;
    logic [4:0]        c;
    logic [3:0]        ns;

    // Select the active nibble and add it with a radix-2 Kogge-Stone prefix tree;
    // the incoming carry is folded into bit 0's generate so the tree stays two levels deep.
    always_comb begin
        nib_lsb = 4 * int'(idx);
        na      = a_r[nib_lsb +: 4];
        nb      = bx_r[nib_lsb +: 4];
        g       = na & nb;
        p       = na ^ nb;

        g0      = {g[3:1], g[0] | (p[0] & carry)};

        g1[0]   = g0[0];
        p1[0]   = p[0];
        g1[1]   = g0[1] | (p[1] & g0[0]);
        p1[1]   = p[1] & p[0];
        g1[2]   = g0[2] | (p[2] & g0[1]);
        p1[2]   = p[2] & p[1];
        g1[3]   = g0[3] | (p[3] & g0[2]);
        p1[3]   = p[3] & p[2];

        g2[0]   = g1[0];
        g2[1]   = g1[1];
        g2[2]   = g1[2] | (p1[2] & g1[0]);
        g2[3]   = g1[3] | (p1[3] & g1[1]);

        c       = {g2, carry};
        ns      = p ^ c[3:0];
    end

    // Sequencer: capture operands on an accepted start, walk the nibbles LSB-first,
    // then publish carry-out and overflow together with the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            a_r   <= '0;
            bx_r  <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        bx_r  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[nib_lsb +: 4] <= ns;
                    carry             <= c[4];
                    if (idx == LAST_IDX) begin
                        cout  <= c[4];
                        ovf   <= c[3] ^ c[4];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        bx_r  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
